// File: rtl/pc_redirect_ctrl_pkg.sv
// rtl/pc_redirect_ctrl_pkg.sv - PC-source select codes and sequencer state encoding
package pc_redirect_ctrl_pkg;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;
  localparam logic [1:0] PCSEL_EXC = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// rtl/pc_redirect_ctrl_if.sv - redirect request / PC-control bundle between pipeline and sequencer
interface pc_redirect_ctrl_if;

  logic       stall;
  logic       br_req;
  logic       j_req;
  logic       exc_req;
  logic [1:0] pcsource;
  logic       pc_we;
  logic       flush;
  logic       redirect_ack;
  logic       pend_valid;

  modport master (
    output stall, br_req, j_req, exc_req,
    input  pcsource, pc_we, flush, redirect_ack, pend_valid
  );

  modport slave (
    input  stall, br_req, j_req, exc_req,
    output pcsource, pc_we, flush, redirect_ack, pend_valid
  );

endinterface

// File: rtl/pc_redirect_ctrl_prio.sv
// rtl/pc_redirect_ctrl_prio.sv - fixed-priority encoder: exception over branch over jump
module pc_redirect_ctrl_prio
  import pc_redirect_ctrl_pkg::*;
(
  input  logic       br_req,
  input  logic       j_req,
  input  logic       exc_req,
  output logic [1:0] sel,
  output logic       valid
);

  // Branch beats jump: the branch is the older instruction in the pipe.
  always_comb begin
    sel   = PCSEL_SEQ;
    valid = 1'b1;
    if (exc_req)     sel = PCSEL_EXC;
    else if (br_req) sel = PCSEL_BR;
    else if (j_req)  sel = PCSEL_JMP;
    else             valid = 1'b0;
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - next-PC sequencer: arbitrates redirects, buffers one across stall, drains stale requests
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  pc_redirect_ctrl_if.slave   ifc
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || FLUSH_CYCLES >= (1 << CNT_W)) begin : g_bad_params
    $error("pc_redirect_ctrl: FLUSH_CYCLES must be 1..7 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES);

  state_e           state_q, state_d;
  logic [1:0]       pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] win_sel;
  logic       win_valid;
  logic [1:0] pcsource_c;
  logic       pc_we_c, flush_c, ack_c;

  pc_redirect_ctrl_prio u_prio (
    .br_req  (ifc.br_req),
    .j_req   (ifc.j_req),
    .exc_req (ifc.exc_req),
    .sel     (win_sel),
    .valid   (win_valid)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    pcsource_c = PCSEL_SEQ;
    pc_we_c    = 1'b0;
    flush_c    = 1'b0;
    ack_c      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!ifc.stall) begin
          pc_we_c    = 1'b1;
          pcsource_c = win_sel;
          if (win_valid) begin
            flush_c = 1'b1;
            ack_c   = 1'b1;
            cnt_d   = CNT_RELOAD;
            state_d = ST_DRAIN;
          end
        end else if (win_valid) begin
          pend_d  = win_sel;
          ack_c   = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        pcsource_c = pend_q;
        if (ifc.stall) begin
          // Only an exception may upgrade the buffered redirect; br/j are younger and stale.
          if (ifc.exc_req && pend_q != PCSEL_EXC) begin
            pend_d = PCSEL_EXC;
            ack_c  = 1'b1;
          end
        end else begin
          pc_we_c    = 1'b1;
          flush_c    = 1'b1;
          pcsource_c = ifc.exc_req ? PCSEL_EXC : pend_q;
          ack_c      = ifc.exc_req && pend_q != PCSEL_EXC;
          cnt_d      = CNT_RELOAD;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ifc.stall) begin
          if (ifc.exc_req) begin
            pend_d  = PCSEL_EXC;
            ack_c   = 1'b1;
            state_d = ST_HOLD;
          end
        end else begin
          pc_we_c = 1'b1;
          if (ifc.exc_req) begin
            pcsource_c = PCSEL_EXC;
            flush_c    = 1'b1;
            ack_c      = 1'b1;
            cnt_d      = CNT_RELOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pend_q  <= PCSEL_SEQ;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are combinational, so reset must also force them directly, not just via state.
  assign ifc.pcsource     = rst_n ? pcsource_c : PCSEL_SEQ;
  assign ifc.pc_we        = rst_n & pc_we_c;
  assign ifc.flush        = rst_n & flush_c;
  assign ifc.redirect_ack = rst_n & ack_c;
  assign ifc.pend_valid   = rst_n & (state_q == ST_HOLD);

endmodule
